bsg_manycore_vcache_dma_to_mem: RTL and testbench
=================================================

// Module: bsg_manycore_vcache_dma_to_mem
// PURPOSE
//  Downstream stage of the manycore vcache DMA port. Accepts one cache DMA packet per block
//  transfer, then either streams block_size_p words read from a synchronous 1-cycle-latency memory
//  back to the cache (fill) or writes block_size_p evicted words from the cache into the memory.
//  Serves one block at a time; the memory side never back-pressures.
// PARAMETERS
//  addr_width_p           28   cache byte-address width; DMA pkt = {write_not_read, addr[addr_width_p-1:0]}
//  data_width_p           32   DMA beat width = memory word width (one beat per block word)
//  block_size_p            8   words per block, power of two, >=2
//  mem_addr_width_p       12   memory word-address width
//  derived: byte_off_lp=clog2(data_width_p/8), blk_off_lp=clog2(block_size_p), pkt_width_lp=addr_width_p+1
// PORTS
//  clk_i              in   1                 clock
//  reset_i            in   1                 asynchronous active-high reset
//  dma_pkt_i          in   pkt_width_lp      DMA packet from cache
//  dma_pkt_v_i        in   1                 packet valid
//  dma_pkt_yumi_o     out  1                 packet consumed this cycle
//  dma_data_o         out  data_width_p      fill data to cache
//  dma_data_v_o       out  1                 fill data valid
//  dma_data_ready_i   in   1                 cache ready for fill data
//  dma_data_i         in   data_width_p      evict data from cache
//  dma_data_v_i       in   1                 evict data valid
//  dma_data_yumi_o    out  1                 evict data consumed this cycle
//  mem_v_o            out  1                 memory access this cycle
//  mem_w_o            out  1                 1=write, 0=read (qualified by mem_v_o)
//  mem_addr_o         out  mem_addr_width_p  memory word address
//  mem_data_o         out  data_width_p      memory write data
//  mem_data_i         in   data_width_p      read data, valid exactly 1 cycle after read issue
// BEHAVIOUR
//  Reset: state=IDLE, counters/FIFO cleared; all outputs 0 (data outputs may be 0, don't-care otherwise).
//  Base word addr = dma_pkt_i[byte_off_lp +: mem_addr_width_p] with low blk_off_lp bits forced 0
//   (block-aligned); captured at pkt accept. Word k of block -> base | k, k=0..block_size_p-1.
//  IDLE: dma_pkt_yumi_o = dma_pkt_v_i (combinational). On accept, latch addr; next state RD if
//   bit[addr_width_p]==0 else WR; issue/recv/write counters reset to 0. No mem access in IDLE.
//  WR: dma_data_yumi_o = dma_data_v_i. Each handshake same cycle: mem_v_o=1, mem_w_o=1,
//   mem_addr_o=base|wcnt, mem_data_o=dma_data_i, wcnt++. After beat block_size_p-1 -> IDLE.
//   dma_data_v_o held 0 in WR.
//  RD: 2-entry FIFO on fill path. Read issued (mem_v_o=1, mem_w_o=0, addr=base|icnt, icnt++) when
//   icnt<block_size_p AND fifo_count+inflight<2, with the same-cycle pop counted as freeing a slot.
//   inflight = read issued previous cycle; its mem_data_i is pushed into FIFO the following cycle.
//   dma_data_v_o = FIFO non-empty; dma_data_o = FIFO head; pop on v_o&ready_i, ocnt++.
//   Push and pop in same cycle allowed (count unchanged). Words delivered in order 0..block_size_p-1.
//   When pop of word block_size_p-1 occurs -> IDLE next cycle; dma_pkt_yumi_o never asserted outside IDLE.
//   dma_data_yumi_o held 0 in RD.
//  Latency: pkt accept at cycle t -> first read issue t+1 -> first dma_data_v_o at t+2. With
//   ready_i held 1, one word per cycle; block complete at t+block_size_p+1; next pkt acceptable t+block_size_p+2.
//  Back-to-back write: pkt at t, beats t+1..t+block_size_p if v_i held, IDLE at t+block_size_p+1.
//  Counters are blk_off_lp+1 bits; no wrap within a block. Address bits above mem_addr_width_p dropped.
//  Reset mid-operation: immediate return to IDLE, FIFO emptied, in-flight read data discarded,
//   partially written block left as-is in memory.
//  No FIFO overflow possible by the issue rule; FIFO never pops when empty.
// TESTING
//  1 Reset: assert reset_i async mid-cycle -> all outputs 0 immediately; IDLE after release.
//  2 Write: pkt {1,0x0000_0124} (word 0x49 -> base 0x48), 8 beats 0xA0..0xA7 back-to-back ->
//    mem writes addr 0x48..0x4F data 0xA0..0xA7, dma_data_yumi_o 8 consecutive cycles.
//  3 Read: preload mem[0x48..0x4F]=0xB0..0xB7, pkt {0,0x0000_0120}, ready_i=1 -> dma_data_o
//    0xB0..0xB7 on 8 consecutive cycles starting 2 cycles after yumi.
//  4 Read backpressure: ready_i random 30% -> same 8 words in order, no loss/dup, mem reads
//    exactly 8, fifo_count never >2.
//  5 Pkt while busy: hold dma_pkt_v_i=1 during a read -> dma_pkt_yumi_o only in IDLE; 2nd block served after.
//  6 Reset during read after 3 words popped -> no further dma_data_v_o; new read pkt returns full block correctly.

Source files
------------

// File: rtl/bsg_manycore_vcache_dma_to_mem.sv
// rtl/bsg_manycore_vcache_dma_to_mem.sv - vcache DMA port to single-cycle synchronous memory bridge
//
// Purpose: accepts one cache DMA packet per block. A read packet streams block_size_p words
// from memory back to the cache through a 2-entry fill FIFO. A write packet writes block_size_p
// evicted words from the cache into memory. One block is in service at a time.
//
// Ports:
//   clk_i, reset_i                       clock, asynchronous active-high reset
//   dma_pkt_i/_v_i, dma_pkt_yumi_o       packet {write_not_read, byte addr} from cache
//   dma_data_o/_v_o, dma_data_ready_i    fill data towards cache
//   dma_data_i/_v_i, dma_data_yumi_o     evict data from cache
//   mem_v_o, mem_w_o, mem_addr_o         memory request (word address)
//   mem_data_o, mem_data_i               memory write data / read data (1-cycle latency)

module bsg_manycore_vcache_dma_to_mem #(
  parameter int addr_width_p     = 28,
  parameter int data_width_p     = 32,
  parameter int block_size_p     = 8,
  parameter int mem_addr_width_p = 12,
  localparam int byte_off_lp     = $clog2(data_width_p/8),
  localparam int blk_off_lp      = $clog2(block_size_p),
  localparam int pkt_width_lp    = addr_width_p + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [pkt_width_lp-1:0]     dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,

  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,

  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o,

  output logic                        mem_v_o,
  output logic                        mem_w_o,
  output logic [mem_addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0]     mem_data_o,
  input  logic [data_width_p-1:0]     mem_data_i
);

  localparam logic [blk_off_lp:0] lp_size = (blk_off_lp+1)'(block_size_p);
  localparam logic [blk_off_lp:0] lp_last = (blk_off_lp+1)'(block_size_p - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t                                   r_state;
  logic [mem_addr_width_p-blk_off_lp-1:0]   r_base_hi;
  logic [blk_off_lp:0]                      r_icnt;
  logic [blk_off_lp:0]                      r_ocnt;
  logic [blk_off_lp:0]                      r_wcnt;
  logic                                     r_inflight;
  logic [data_width_p-1:0]                  r_fifo [2];
  logic                                     r_rd_ptr;
  logic                                     r_wr_ptr;
  logic [1:0]                               r_count;

  logic [mem_addr_width_p-1:0]              w_pkt_word;
  logic                                     w_unused;
  logic                                     w_pkt_acc;
  logic                                     w_wr_hs;
  logic                                     w_fill_v;
  logic                                     w_pop;
  logic                                     w_bypass;
  logic                                     w_push;
  logic                                     w_fifo_pop;
  logic [2:0]                               w_occ_after_pop;
  logic                                     w_issue;
  logic [blk_off_lp:0]                      w_k;

  assign w_pkt_word = dma_pkt_i[byte_off_lp +: mem_addr_width_p];
  // Byte offset, bits above the memory range and in-block word bits are intentionally dropped.
  assign w_unused   = ^{dma_pkt_i[byte_off_lp-1:0],
                        dma_pkt_i[addr_width_p-1:byte_off_lp+mem_addr_width_p],
                        w_pkt_word[blk_off_lp-1:0]};

  assign w_pkt_acc  = (r_state == S_IDLE) && dma_pkt_v_i && !reset_i;
  assign w_wr_hs    = (r_state == S_WR) && dma_data_v_i;

  // The read returning this cycle is visible at the fill port straight from mem_data_i when the
  // FIFO is empty, so the first word reaches the cache one cycle after its read is issued.
  assign w_fill_v   = (r_state == S_RD) && ((r_count != 2'd0) || r_inflight);
  assign w_pop      = w_fill_v && dma_data_ready_i;
  assign w_bypass   = w_pop && (r_count == 2'd0);
  assign w_push     = r_inflight && !w_bypass;
  assign w_fifo_pop = w_pop && (r_count != 2'd0);

  // Slots already owned (stored + returning) minus the one being freed by this cycle's pop.
  assign w_occ_after_pop = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = (r_state == S_RD) && (r_icnt < lp_size) && (w_occ_after_pop < 3'd2);

  assign w_k        = w_wr_hs ? r_wcnt : r_icnt;

  assign dma_pkt_yumi_o  = w_pkt_acc;
  assign dma_data_v_o    = w_fill_v;
  assign dma_data_o      = !w_fill_v ? '0 : (r_count != 2'd0) ? r_fifo[r_rd_ptr] : mem_data_i;
  assign dma_data_yumi_o = w_wr_hs;
  assign mem_v_o         = w_issue || w_wr_hs;
  assign mem_w_o         = w_wr_hs;
  assign mem_addr_o      = mem_v_o ? {r_base_hi, w_k[blk_off_lp-1:0]} : '0;
  assign mem_data_o      = w_wr_hs ? dma_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= mem_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_base_hi  <= '0;
      r_icnt     <= '0;
      r_ocnt     <= '0;
      r_wcnt     <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pkt_acc) begin
            r_base_hi  <= w_pkt_word[mem_addr_width_p-1:blk_off_lp];
            r_icnt     <= '0;
            r_ocnt     <= '0;
            r_wcnt     <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_state    <= dma_pkt_i[addr_width_p] ? S_WR : S_RD;
          end
        end
        S_RD: begin
          r_inflight <= w_issue;
          if (w_issue)    r_icnt   <= r_icnt + 1'b1;
          if (w_push)     r_wr_ptr <= ~r_wr_ptr;
          if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
          r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
          if (w_pop) begin
            r_ocnt <= r_ocnt + 1'b1;
            if (r_ocnt == lp_last) begin
              r_state    <= S_IDLE;
              r_inflight <= 1'b0;
              r_count    <= 2'd0;
              r_rd_ptr   <= 1'b0;
              r_wr_ptr   <= 1'b0;
            end
          end
        end
        S_WR: begin
          if (w_wr_hs) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == lp_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_dma_to_mem.sv
// tb/tb_bsg_manycore_vcache_dma_to_mem.sv - directed bench for bsg_manycore_vcache_dma_to_mem

module tb_bsg_manycore_vcache_dma_to_mem;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [28:0] dma_pkt_i;
  logic        dma_pkt_v_i;
  logic        dma_pkt_yumi_o;
  logic [31:0] dma_data_o;
  logic        dma_data_v_o;
  logic        dma_data_ready_i;
  logic [31:0] dma_data_i;
  logic        dma_data_v_i;
  logic        dma_data_yumi_o;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;

  logic [31:0] mem [0:4095];

  int total = 0;
  int bad   = 0;
  int got;
  int reads;

  bsg_manycore_vcache_dma_to_mem dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .dma_pkt_i        (dma_pkt_i),
    .dma_pkt_v_i      (dma_pkt_v_i),
    .dma_pkt_yumi_o   (dma_pkt_yumi_o),
    .dma_data_o       (dma_data_o),
    .dma_data_v_o     (dma_data_v_o),
    .dma_data_ready_i (dma_data_ready_i),
    .dma_data_i       (dma_data_i),
    .dma_data_v_i     (dma_data_v_i),
    .dma_data_yumi_o  (dma_data_yumi_o),
    .mem_v_o          (mem_v_o),
    .mem_w_o          (mem_w_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .mem_data_i       (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) mem[mem_addr_o] <= mem_data_o;
      else         mem_data_i      <= mem[mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic write_block(input logic [27:0] addr, input logic [31:0] d0, input logic [11:0] base);
    tick();
    dma_pkt_v_i = 1'b1;
    dma_pkt_i   = {1'b1, addr};
    #1;
    chk("wr_pkt_yumi", {31'b0, dma_pkt_yumi_o}, 32'd1);
    chk("wr_idle_no_mem", {31'b0, mem_v_o}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      dma_pkt_v_i  = 1'b0;
      dma_data_v_i = 1'b1;
      dma_data_i   = d0 + 32'(k);
      #1;
      chk("wr_data_yumi", {31'b0, dma_data_yumi_o}, 32'd1);
      chk("wr_mem_vw", {30'b0, mem_v_o, mem_w_o}, 32'd3);
      chk("wr_mem_addr", {20'b0, mem_addr_o}, {20'b0, base} + 32'(k));
      chk("wr_mem_data", mem_data_o, d0 + 32'(k));
      chk("wr_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    end
    tick();
    dma_data_v_i = 1'b0;
    #1;
    chk("wr_done_no_mem", {31'b0, mem_v_o}, 32'd0);
  endtask

  task automatic collect(input logic [31:0] d0, input logic [11:0] base, input int pct, input logic hold);
    got   = 0;
    reads = 0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      tick();
      dma_pkt_v_i      = hold;
      dma_data_ready_i = ($urandom_range(0, 99) < pct);
      #1;
      chk("busy_pkt_yumi", {31'b0, dma_pkt_yumi_o}, 32'd0);
      if (mem_v_o) begin
        chk("rd_mem_w", {31'b0, mem_w_o}, 32'd0);
        chk("rd_mem_addr", {20'b0, mem_addr_o}, {20'b0, base} + 32'(reads));
        reads++;
      end
      if (dma_data_v_o && dma_data_ready_i) begin
        chk("rd_word", dma_data_o, d0 + 32'(got));
        got++;
      end
      chk("rd_occupancy_le2", {31'b0, (reads - got) <= 2}, 32'd1);
    end
    chk("rd_words_delivered", got, 32'd8);
    chk("rd_reads_issued", reads, 32'd8);
  endtask

  task automatic accept_read(input logic [27:0] addr);
    tick();
    dma_pkt_v_i = 1'b1;
    dma_pkt_i   = {1'b0, addr};
    #1;
    chk("rd_pkt_yumi", {31'b0, dma_pkt_yumi_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i          = 1'b1;
    dma_pkt_i        = '0;
    dma_pkt_v_i      = 1'b1;
    dma_data_ready_i = 1'b0;
    dma_data_i       = '0;
    dma_data_v_i     = 1'b0;
    #2;
    chk("rst_pkt_yumi", {31'b0, dma_pkt_yumi_o}, 32'd0);
    chk("rst_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    chk("rst_data_yumi", {31'b0, dma_data_yumi_o}, 32'd0);
    chk("rst_mem_v", {31'b0, mem_v_o}, 32'd0);
    tick();
    reset_i     = 1'b0;
    dma_pkt_v_i = 1'b0;
    #1;
    chk("idle_no_mem", {31'b0, mem_v_o}, 32'd0);

    // Write block at byte 0x124 -> word 0x49 -> block base 0x48.
    write_block(28'h124, 32'hA0, 12'h048);
    for (int k = 0; k < 8; k++) chk("mem_after_write", mem[12'h048 + k], 32'hA0 + 32'(k));
    write_block(28'h120, 32'hB0, 12'h048);
    write_block(28'h400, 32'hC0, 12'h100);

    // Read with ready held: words on 8 consecutive cycles starting 2 cycles after accept.
    dma_data_ready_i = 1'b1;
    accept_read(28'h120);
    chk("rd_accept_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    tick();
    dma_pkt_v_i = 1'b0;
    #1;
    chk("rd_first_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    chk("rd_first_issue", {19'b0, mem_v_o, mem_addr_o}, 32'h1048);
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      chk("rd_stream_v", {31'b0, dma_data_v_o}, 32'd1);
      chk("rd_stream_data", dma_data_o, 32'hB0 + 32'(k));
    end
    tick();
    #1;
    chk("rd_end_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    chk("rd_end_mem_v", {31'b0, mem_v_o}, 32'd0);

    // Read with random 30% ready.
    accept_read(28'h400);
    collect(32'hC0, 12'h100, 30, 1'b0);
    tick();
    dma_data_ready_i = 1'b0;
    #1;
    chk("bp_end_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    chk("bp_end_mem_v", {31'b0, mem_v_o}, 32'd0);

    // Packet valid held through a read: yumi only once back in IDLE.
    accept_read(28'h120);
    collect(32'hB0, 12'h048, 100, 1'b1);
    tick();
    #1;
    chk("second_pkt_yumi", {31'b0, dma_pkt_yumi_o}, 32'd1);
    collect(32'hB0, 12'h048, 100, 1'b0);

    // Reset after 3 words popped.
    accept_read(28'h400);
    tick();
    dma_pkt_v_i      = 1'b0;
    dma_data_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("pre_rst_word", dma_data_o, 32'hC0 + 32'(k));
    end
    tick();
    dma_data_ready_i = 1'b0;
    #1;
    chk("pre_rst_fill_v", {31'b0, dma_data_v_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("async_rst_fill_v", {31'b0, dma_data_v_o}, 32'd0);
    chk("async_rst_mem_v", {31'b0, mem_v_o}, 32'd0);
    chk("async_rst_data_yumi", {31'b0, dma_data_yumi_o}, 32'd0);
    tick();
    reset_i          = 1'b0;
    dma_data_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_fill_v", {31'b0, dma_data_v_o}, 32'd0);
      chk("post_rst_mem_v", {31'b0, mem_v_o}, 32'd0);
      tick();
    end
    accept_read(28'h124);
    collect(32'hB0, 12'h048, 100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
